mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Execute-stage controller directly upstream of the iterative multiplier. It decodes RV32M multiply instructions (funct3 000-011) and launches the multiplier with a one-cycle start pulse. It stalls the pipeline while the multiplier runs, then captures the result and presents it for writeback with its destination register. It also handles pipeline flush, a watchdog timeout, and back-to-back multiply requests.

Parameters:
XLEN, 32, operand/result width
TIMEOUT_CYCLES, 40, cycles in WAIT without done before abort
CNT_W, 6, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_ex  in  1  execute-stage instruction valid
is_mul  in  1  decoded OP with funct7=0000001
funct3  in  3  instruction funct3
rs1_data  in  XLEN  operand 1
rs2_data  in  XLEN  operand 2
rd_addr  in  5  destination register
flush  in  1  squash the in-flight execute instruction
result_multiply  in  XLEN  multiplier result
done  in  1  multiplier completion pulse
startM  out  1  multiplier start pulse
mul_opcode  out  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
operand1  out  XLEN  latched rs1
operand2  out  XLEN  latched rs2
stall_mul  out  1  hold IF/ID/EX
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  XLEN  writeback data
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, active-high, from any state): state=IDLE; all outputs and registers 0.
- req = valid_ex & is_mul & ~funct3[2] & ~flush. funct3[2]=1 (divide ops) is never accepted; there is no stall and no start for it.
- mul_opcode = funct3[1:0], registered at accept together with operand1, operand2 and rd.
- FSM states:
  - IDLE: on req, latch fields and go to LAUNCH. stall_mul = req (combinational).
  - LAUNCH: startM=1 for exactly one cycle. Clear watchdog. Go to WAIT. stall_mul=1.
  - WAIT: stall_mul=1; watchdog increments each cycle.
    - On done: capture result_multiply into wb_data, go to RESP.
    - If watchdog reaches TIMEOUT_CYCLES-1 without done: pulse err_timeout, go to IDLE, no writeback.
  - RESP: wb_valid=1, wb_rd and wb_data valid, stall_mul=0. Go to IDLE next cycle. A new req in RESP is accepted directly (to LAUNCH).
  - DRAIN: entered from LAUNCH/WAIT when flush=1 (startM still issues if flush arrives in LAUNCH).
    - Waits for done or timeout, discards the result, then goes to IDLE. There is no wb_valid and no err_timeout from a flush drain.
    - stall_mul = req while in DRAIN; the new request is latched only after returning to IDLE.
- done outside WAIT/DRAIN is ignored.
- Latency: req at cycle T, startM at T+1. wb_valid comes 1 cycle after done is sampled in WAIT.
- operand1/operand2/mul_opcode hold stable from LAUNCH until leaving WAIT/DRAIN.
- flush in RESP does not cancel wb_valid; the instruction has already completed.

Optional Feature:
MUL_RESULT_CACHE_EN
- With the macro defined: keep one entry {opcode, rs1, rs2, result}, valid bit cleared on reset. It is written on every RESP.
  - A req matching the valid entry skips LAUNCH/WAIT and goes straight to RESP with the cached data. This gives wb_valid at T+1, no startM, and stall_mul=1 only in cycle T.
- Without the macro: no cache storage exists; every req launches the multiplier.

Test Plan:
1. MUL rs1=7, rs2=6, rd=5 → one startM at T+1, mul_opcode=00, stall_mul high until RESP, then wb_valid=1, wb_rd=5, wb_data=42.
2. MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, rd=10 → mul_opcode=11, wb_data=0xFFFFFFFE, exactly one wb_valid pulse.
3. funct3=100 with is_mul=1 → no startM, stall_mul=0, no wb_valid.
4. MUL 3×3 with flush during WAIT → DRAIN, done consumed, no wb_valid. A following MUL 2×5 gives wb_data=10.
5. Multiplier model never asserts done → err_timeout pulses TIMEOUT_CYCLES cycles after LAUNCH, state=IDLE, stall_mul=0. An rst pulse mid-WAIT returns all outputs to 0.
6. (MUL_RESULT_CACHE_EN) Two back-to-back MUL 7×6 → the second gives no startM, wb_valid at T+1, wb_data=42.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues RV32M MUL/MULH/MULHSU/MULHU to the iterative multiplier.
// Optional single-entry result cache is enabled with MUL_RESULT_CACHE_EN.
module mul_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_ex,
  input  logic            is_mul,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  input  logic [XLEN-1:0] result_multiply,
  input  logic            done,
  output logic            startM,
  output logic [1:0]      mul_opcode,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic            stall_mul,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [4:0]      rd_q, rd_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic            startm_q, startm_d;
  logic            wb_valid_q, wb_valid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            req;
  logic            accept;
  logic            wdog_hit;
  logic            stall;
  logic            hit;
  logic [XLEN-1:0] hit_data;

  assign req      = valid_ex & is_mul & ~funct3[2] & ~flush;
  assign wdog_hit = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MUL_RESULT_CACHE_EN
  logic            c_vld_q, c_vld_d;
  logic [1:0]      c_op_q, c_op_d;
  logic [XLEN-1:0] c_a_q, c_a_d;
  logic [XLEN-1:0] c_b_q, c_b_d;
  logic [XLEN-1:0] c_res_q, c_res_d;

  assign hit = c_vld_q
             && (c_op_q == funct3[1:0])
             && (c_a_q == rs1_data)
             && (c_b_q == rs2_data);
  assign hit_data = c_res_q;

  // Entry is refreshed as the multiplier result is captured for RESP.
  always_comb begin
    c_vld_d = c_vld_q;
    c_op_d  = c_op_q;
    c_a_d   = c_a_q;
    c_b_d   = c_b_q;
    c_res_d = c_res_q;
    if (state_q == S_WAIT && !flush && done) begin
      c_vld_d = 1'b1;
      c_op_d  = op_q;
      c_a_d   = op1_q;
      c_b_d   = op2_q;
      c_res_d = result_multiply;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    rd_d       = rd_q;
    wdog_d     = wdog_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall  = req;
        accept = req;
      end
      S_LAUNCH: begin
        stall   = 1'b1;
        wdog_d  = '0;
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall  = 1'b1;
        wdog_d = wdog_q + CNT_W'(1);
        if (flush) begin
          state_d = (done || wdog_hit) ? S_IDLE : S_DRAIN;
        end else if (done) begin
          wb_data_d = result_multiply;
          state_d   = S_RESP;
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        accept  = req;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Squashed op: only wait for the multiplier to go quiet.
        stall  = req;
        wdog_d = wdog_q + CNT_W'(1);
        if (done || wdog_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      op_d  = funct3[1:0];
      op1_d = rs1_data;
      op2_d = rs2_data;
      rd_d  = rd_addr;
      if (hit) begin
        wb_data_d = hit_data;
        state_d   = S_RESP;
      end else begin
        state_d = S_LAUNCH;
      end
    end
    startm_d   = (state_d == S_LAUNCH);
    wb_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_q       <= '0;
      wdog_q     <= '0;
      startm_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wb_data_q  <= '0;
`ifdef MUL_RESULT_CACHE_EN
      c_vld_q    <= 1'b0;
      c_op_q     <= '0;
      c_a_q      <= '0;
      c_b_q      <= '0;
      c_res_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rd_q       <= rd_d;
      wdog_q     <= wdog_d;
      startm_q   <= startm_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
      wb_data_q  <= wb_data_d;
`ifdef MUL_RESULT_CACHE_EN
      c_vld_q    <= c_vld_d;
      c_op_q     <= c_op_d;
      c_a_q      <= c_a_d;
      c_b_q      <= c_b_d;
      c_res_q    <= c_res_d;
`endif
    end
  end

  assign startM      = startm_q;
  assign mul_opcode  = op_q;
  assign operand1    = op1_q;
  assign operand2    = op2_q;
  assign stall_mul   = stall;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = rd_q;
  assign wb_data     = wb_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed + random checks of mul_issue_ctrl against a
// multiply reference, with a behavioural iterative-multiplier responder.
module tb_mul_issue_ctrl;

  localparam int XLEN = 32;
  localparam int TO   = 40;
`ifdef MUL_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_ex = 1'b0;
  logic            is_mul = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [4:0]      rd_addr = '0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] result_multiply;
  logic            done;
  logic            startM;
  logic [1:0]      mul_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            stall_mul;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            err_timeout;

  mul_issue_ctrl #(
    .XLEN(XLEN), .TIMEOUT_CYCLES(TO), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_ex(valid_ex), .is_mul(is_mul), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .flush(flush),
    .result_multiply(result_multiply), .done(done),
    .startM(startM), .mul_opcode(mul_opcode),
    .operand1(operand1), .operand2(operand2),
    .stall_mul(stall_mul),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit in_resp = 1'b0;

  // result-reuse model: last multiply that completed with writeback
  bit          cvld = 1'b0;
  logic [1:0]  cop = '0;
  logic [31:0] ca = '0;
  logic [31:0] cb = '0;

  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // iterative multiplier stand-in
  int   mul_lat = 3;
  bit   mul_dead = 1'b0;
  int   mcnt = 0;
  logic done_m = 1'b0;
  logic done_x = 1'b0;

  assign done = done_m | done_x;
  assign result_multiply = ref_mul(mul_opcode, operand1, operand2);

  always @(posedge clk) begin
    done_m <= 1'b0;
    if (rst) mcnt <= 0;
    else if (startM && !mul_dead) mcnt <= mul_lat;
    else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) done_m <= 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    valid_ex = 1'b1;
    is_mul   = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
  endtask

  task automatic release_req();
    valid_ex = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_addr  = 5'($urandom);
  endtask

  // called in the LAUNCH cycle; returns in the writeback cycle
  task automatic wait_wb(input logic [31:0] ed, input logic [4:0] er,
                         input string tag);
    int dcyc = -100;
    int extra = 0;
    bit got = 1'b0;
    bit stall_bad = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (wb_valid) begin
        got = 1'b1;
        chk({tag, "_wb_after_done"}, 64'(cyc - dcyc), 64'd1);
        chk({tag, "_wb_data"}, wb_data, ed);
        chk({tag, "_wb_rd"}, wb_rd, er);
        chk({tag, "_stall_resp"}, stall_mul, 0);
      end else begin
        if (startM) extra++;
        if (!stall_mul) stall_bad = 1'b1;
        if (done) dcyc = cyc;
      end
    end
    chk({tag, "_wb_seen"}, got, 1);
    chk({tag, "_one_start"}, extra, 0);
    chk({tag, "_stall_busy"}, stall_bad, 0);
    in_resp = 1'b1;
  endtask

  task automatic run_mul(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int lat, input string tag);
    bit hit;
    logic [31:0] exp;
    hit = CACHE && cvld && cop == op && ca == a && cb == b;
    exp = ref_mul(op, a, b);
    mul_lat = lat;
    flush = 1'b0;
    drive({1'b0, op}, a, b, rd);
    #1;
    chk({tag, "_stall_T"}, stall_mul, in_resp ? 0 : 1);
    step();
    release_req();
    if (hit) begin
      chk({tag, "_hit_wb"}, wb_valid, 1);
      chk({tag, "_hit_data"}, wb_data, exp);
      chk({tag, "_hit_rd"}, wb_rd, rd);
      chk({tag, "_hit_nostart"}, startM, 0);
      chk({tag, "_hit_stall"}, stall_mul, 0);
      in_resp = 1'b1;
    end else begin
      chk({tag, "_start"}, startM, 1);
      chk({tag, "_opcode"}, mul_opcode, op);
      chk({tag, "_ops"}, {operand1, operand2}, {a, b});
      wait_wb(exp, rd, tag);
      cvld = 1'b1;
      cop  = op;
      ca   = a;
      cb   = b;
    end
  endtask

  task automatic idle(input int n, input string tag);
    bit bad = 1'b0;
    valid_ex = 1'b0;
    is_mul   = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (wb_valid || startM || err_timeout) bad = 1'b1;
    end
    chk({tag, "_quiet"}, bad, 0);
    in_resp = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 5);
    case (s)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dcyc;
    int scyc;
    int errk;
    int nerr;
    bit bad;
    bit sbad;

    step();
    step();
    chk("reset_ctl", {startM, stall_mul, wb_valid, err_timeout,
                      mul_opcode, wb_rd}, 0);
    chk("reset_ops", {operand1, operand2}, 0);
    chk("reset_wbd", wb_data, 0);
    rst = 1'b0;
    idle(2, "post_reset");

    // basic MUL and MULHU
    run_mul(2'b00, 32'd7, 32'd6, 5'd5, 3, "t1_mul");
    idle(2, "t1");
    run_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 5, "t2_mulhu");
    idle(2, "t2");

    // divide encoding plus a stray done while idle
    drive(3'b100, 32'd9, 32'd3, 5'd4);
    done_x = 1'b1;
    #1;
    chk("t3_div_stall", stall_mul, 0);
    step();
    done_x = 1'b0;
    release_req();
    chk("t3_div_nostart", startM, 0);
    idle(4, "t3");

    // flush while waiting; the next request is held across the drain
    mul_lat = 6;
    drive(3'b000, 32'd3, 32'd3, 5'd7);
    #1;
    chk("t4_stall_T", stall_mul, 1);
    step();
    release_req();
    chk("t4_start", startM, 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(3'b000, 32'd2, 32'd5, 5'd9);
    dcyc = -100;
    scyc = -1;
    bad  = 1'b0;
    sbad = 1'b0;
    for (int i = 0; i < 40 && scyc < 0; i++) begin
      #1;
      if (!stall_mul) sbad = 1'b1;
      if (wb_valid || err_timeout) bad = 1'b1;
      if (done) dcyc = cyc;
      step();
      if (startM) scyc = cyc;
    end
    release_req();
    chk("t4_no_wb_drain", bad, 0);
    chk("t4_stall_drain", sbad, 0);
    chk("t4_relaunch", 64'(scyc - dcyc), 64'd2);
    chk("t4_ops", {operand1, operand2}, {32'd2, 32'd5});
    wait_wb(32'd10, 5'd9, "t4_mul2x5");
    cvld = 1'b1;
    cop  = 2'b00;
    ca   = 32'd2;
    cb   = 32'd5;
    idle(2, "t4");

    // watchdog abort
    mul_dead = 1'b1;
    drive(3'b000, 32'd3, 32'd4, 5'd3);
    #1;
    step();
    release_req();
    chk("t5_start", startM, 1);
    errk = -1;
    nerr = 0;
    bad  = 1'b0;
    sbad = 1'b0;
    for (int k = 1; k <= TO + 4; k++) begin
      step();
      if (err_timeout) begin
        nerr++;
        if (errk < 0) begin
          errk = k;
          chk("t5_stall_at_err", stall_mul, 0);
        end
      end
      if (wb_valid) bad = 1'b1;
      if (k <= TO && !stall_mul) sbad = 1'b1;
    end
    chk("t5_err_cycle", errk, TO + 1);
    chk("t5_err_pulses", nerr, 1);
    chk("t5_no_wb", bad, 0);
    chk("t5_stall_wait", sbad, 0);

    // async reset in the middle of WAIT
    drive(3'b011, 32'h1234, 32'h55, 5'd17);
    #1;
    step();
    release_req();
    chk("t5b_start", startM, 1);
    repeat (4) step();
    chk("t5b_busy", stall_mul, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t5b_rst_ctl", {startM, stall_mul, wb_valid, err_timeout,
                        mul_opcode, wb_rd}, 0);
    chk("t5b_rst_ops", {operand1, operand2}, 0);
    chk("t5b_rst_wbd", wb_data, 0);
    step();
    rst = 1'b0;
    mul_dead = 1'b0;
    cvld = 1'b0;
    in_resp = 1'b0;
    idle(2, "t5b");
    run_mul(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 2, "t5c_mulh");
    idle(1, "t5c");

    // back-to-back identical requests
    run_mul(2'b00, 32'd7, 32'd6, 5'd12, 3, "t6_first");
    run_mul(2'b00, 32'd7, 32'd6, 5'd13, 3, "t6_second");
    idle(2, "t6");

    // random traffic, including back-to-back issue in RESP
    for (int n = 0; n < 24; n++) begin
      int gap;
      run_mul(2'($urandom_range(0, 3)), pick(), pick(),
              5'($urandom_range(0, 31)), $urandom_range(1, 8), "rnd");
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap, "rnd");
    end
    idle(2, "end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
